// File: rtl/uart_pkg.sv
// Shared UART receiver declarations: parity modes, RX FSM state encoding, parity helper.
// Declarations only; no latency or flow control of its own.
package uart_pkg;

  localparam int PARITY_NONE   = 0;
  localparam int PARITY_ODD    = 1;
  localparam int PARITY_EVEN   = 2;
  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// RX line 2-flop synchronizer plus 3-sample majority filter when UART_RX_MAJORITY_EN is defined.
// s lags serial by 2 clocks, s_filt is combinational over the s history; no flow control.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic serial,
  output logic s,
  output logic s_filt
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= serial;
      sync_q <= meta_q;
    end
  end

  assign s = sync_q;

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] is s one clock ago, hist_q[1] two clocks ago
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], sync_q};
    end
  end

  assign s_filt = (sync_q & hist_q[0]) | (sync_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign s_filt = sync_q;
`endif

endmodule

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver (5-9 data bits, none/odd/even parity, 1-2 stop bits); UART_RX_MAJORITY_EN enables majority sampling.
// ready pulses 3+HALF_CLK+CLK_PER_BIT*frame_bits clocks after the start edge; no backpressure, data holds until the next good frame.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int DATA_BIT_COUNT = 8,
  parameter int PARITY_MODE    = 0,
  parameter int STOP_BIT_COUNT = 1,
  parameter int CLK_PER_BIT    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      serial,
  output logic                      ready,
  output logic [DATA_BIT_COUNT-1:0] data,
  output logic                      parity_err,
  output logic                      frame_err,
  output logic                      busy
);

  localparam int HALF_CLK = (CLK_PER_BIT - 1) / 2;
  localparam int BW       = $clog2(DATA_BIT_COUNT + 1);
  localparam int BW1      = BW + 1;
  localparam int CW       = $clog2(CLK_PER_BIT);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(HALF_CLK);
  localparam logic [BW:0]   LAST_DATA = BW1'(DATA_BIT_COUNT - 1);
  localparam logic [BW:0]   LAST_STOP = BW1'(STOP_BIT_COUNT - 1);

  if (DATA_BIT_COUNT < 5 || DATA_BIT_COUNT > 9) begin : g_bad_data_bits
    $error("uart_rx_ext: DATA_BIT_COUNT must be 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity_mode
    $error("uart_rx_ext: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BIT_COUNT < 1 || STOP_BIT_COUNT > 2) begin : g_bad_stop_bits
    $error("uart_rx_ext: STOP_BIT_COUNT must be 1 or 2");
  end
  if (CLK_PER_BIT < 4) begin : g_bad_clk_per_bit
    $error("uart_rx_ext: CLK_PER_BIT must be at least 4");
  end

  logic s;
  logic s_filt;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .serial (serial),
    .s      (s),
    .s_filt (s_filt)
  );

  rx_state_t                 state_q, state_d;
  logic [CW-1:0]             clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]             bit_idx_q, bit_idx_d;
  logic [DATA_BIT_COUNT-1:0] shreg_q, shreg_d;
  logic                      perr_pend_q, perr_pend_d;
  logic [DATA_BIT_COUNT-1:0] data_q, data_d;
  logic                      parity_err_q, parity_err_d;
  logic                      ready_q, ready_d;
  logic                      frame_err_q, frame_err_d;

  logic [MAX_DATA_BITS-1:0] shreg_ext;
  logic                     par_mismatch;
  logic                     tick;

  assign shreg_ext    = MAX_DATA_BITS'(shreg_q);
  assign par_mismatch = parity_of(shreg_ext) ^ s_filt ^ (PARITY_MODE == PARITY_ODD);
  assign tick         = (clk_cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      perr_pend_q  <= 1'b0;
      data_q       <= '0;
      parity_err_q <= 1'b0;
      ready_q      <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      perr_pend_q  <= perr_pend_d;
      data_q       <= data_d;
      parity_err_q <= parity_err_d;
      ready_q      <= ready_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    perr_pend_d  = perr_pend_q;
    data_d       = data_q;
    parity_err_d = parity_err_q;
    ready_d      = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (!s) state_d = START;
      end
      START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          state_d   = s_filt ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (tick) begin
          clk_cnt_d = '0;
          shreg_d   = {s_filt, shreg_q[DATA_BIT_COUNT-1:1]};
          bit_idx_d = bit_idx_q + BW'(1);
          if ({1'b0, bit_idx_q} == LAST_DATA) begin
            bit_idx_d = '0;
            state_d   = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      PARITY: begin
        if (tick) begin
          clk_cnt_d   = '0;
          perr_pend_d = par_mismatch;
          state_d     = STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (tick) begin
          clk_cnt_d = '0;
          if (!s_filt) begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end else if ({1'b0, bit_idx_q} == LAST_STOP) begin
            // Leaving mid-stop-bit is safe: the line is still high here.
            data_d       = shreg_q;
            parity_err_d = perr_pend_q;
            ready_d      = 1'b1;
            state_d      = IDLE;
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready      = ready_q;
  assign data       = data_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: 8N1, 7E1 and 8N2 instances fed from a frame table plus corner-case sequences.
// UART_RX_MAJORITY_EN, when defined, adds the in-bit noise rejection sequence.
module tb_uart_rx_ext;

  localparam int CPB = 8;

  logic       clk;
  logic       rst_n;
  logic [2:0] ser;
  logic [2:0] rdy;
  logic [2:0] perr;
  logic [2:0] fe;
  logic [2:0] busy;
  logic [7:0] d8n1;
  logic [6:0] d7e1;
  logic [7:0] d8n2;

  uart_rx_ext #(.DATA_BIT_COUNT(8), .PARITY_MODE(0), .STOP_BIT_COUNT(1), .CLK_PER_BIT(CPB)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .serial(ser[0]), .ready(rdy[0]), .data(d8n1),
    .parity_err(perr[0]), .frame_err(fe[0]), .busy(busy[0])
  );
  uart_rx_ext #(.DATA_BIT_COUNT(7), .PARITY_MODE(2), .STOP_BIT_COUNT(1), .CLK_PER_BIT(CPB)) u_7e1 (
    .clk(clk), .rst_n(rst_n), .serial(ser[1]), .ready(rdy[1]), .data(d7e1),
    .parity_err(perr[1]), .frame_err(fe[1]), .busy(busy[1])
  );
  uart_rx_ext #(.DATA_BIT_COUNT(8), .PARITY_MODE(0), .STOP_BIT_COUNT(2), .CLK_PER_BIT(CPB)) u_8n2 (
    .clk(clk), .rst_n(rst_n), .serial(ser[2]), .ready(rdy[2]), .data(d8n2),
    .parity_err(perr[2]), .frame_err(fe[2]), .busy(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         cyc = 0;
  int         rdy_cnt[3] = '{0, 0, 0};
  int         fe_cnt[3]  = '{0, 0, 0};
  int         rdy_cyc[3] = '{0, 0, 0};
  int         proto_err  = 0;
  logic [2:0] rdy_prev   = '0;
  logic [2:0] fe_prev    = '0;
  logic [7:0] q0[$];
  int         n_checks   = 0;
  int         n_errs     = 0;
  int         start_cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counting and protocol watch, sampled on the falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rdy[k]) begin
        rdy_cnt[k] <= rdy_cnt[k] + 1;
        rdy_cyc[k] <= cyc;
      end
      if (fe[k]) fe_cnt[k] <= fe_cnt[k] + 1;
      if ((rdy[k] && fe[k]) || (rdy[k] && rdy_prev[k]) || (fe[k] && fe_prev[k]))
        proto_err <= proto_err + 1;
    end
    if (rdy[0]) q0.push_back(d8n1);
    rdy_prev <= rdy;
    fe_prev  <= fe;
  end

  function automatic logic [8:0] dout(input int d);
    case (d)
      0:       return {1'b0, d8n1};
      1:       return {2'b0, d7e1};
      default: return {1'b0, d8n2};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errs++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Drives one frame on line d, starting at a falling edge; stop bit stop_low (if >= 0) is sent low.
  task automatic send(input int d, input logic [8:0] dat, input int nd, input int par,
                      input int nstop, input int stop_low, input int gap);
    logic [15:0] bits;
    int          nb;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < nd; i++) bits[1+i] = dat[i];
    nb = 1 + nd;
    if (par >= 0) begin
      bits[nb] = par[0];
      nb++;
    end
    for (int i = 0; i < nstop; i++) begin
      bits[nb] = (i == stop_low) ? 1'b0 : 1'b1;
      nb++;
    end
    start_cyc = cyc;
    for (int j = 0; j < nb * CPB; j++) begin
      ser[d] = bits[j / CPB];
      @(negedge clk);
    end
    ser[d] = 1'b1;
    repeat (gap * CPB) @(negedge clk);
  endtask

  typedef struct {
    int         d;
    logic [8:0] dat;
    int         nd;
    int         par;
    int         nstop;
    int         stop_low;
    int         exp_rdy;
    int         exp_fe;
    logic [8:0] exp_data;
    logic       exp_perr;
    int         lat;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, f0, qs, bcnt;

    vecs[0]  = '{0, 9'h0A5, 8, -1, 1, -1, 1, 0, 9'h0A5, 1'b0, 78};
    vecs[1]  = '{0, 9'h000, 8, -1, 1, -1, 1, 0, 9'h000, 1'b0, 78};
    vecs[2]  = '{0, 9'h0FF, 8, -1, 1, -1, 1, 0, 9'h0FF, 1'b0, 78};
    vecs[3]  = '{0, 9'h012, 8, -1, 1,  0, 0, 1, 9'h0FF, 1'b0, 78};
    vecs[4]  = '{1, 9'h041, 7,  0, 1, -1, 1, 0, 9'h041, 1'b0, 78};
    vecs[5]  = '{1, 9'h041, 7,  1, 1, -1, 1, 0, 9'h041, 1'b1, 78};
    vecs[6]  = '{1, 9'h07F, 7,  1, 1, -1, 1, 0, 9'h07F, 1'b0, 78};
    vecs[7]  = '{1, 9'h02A, 7,  0, 1, -1, 1, 0, 9'h02A, 1'b1, 78};
    vecs[8]  = '{1, 9'h02A, 7,  1, 1, -1, 1, 0, 9'h02A, 1'b0, 78};
    vecs[9]  = '{2, 9'h096, 8, -1, 2, -1, 1, 0, 9'h096, 1'b0, 86};
    vecs[10] = '{2, 9'h03C, 8, -1, 2,  1, 0, 1, 9'h096, 1'b0, 86};
    vecs[11] = '{2, 9'h03C, 8, -1, 2, -1, 1, 0, 9'h03C, 1'b0, 86};
    vecs[12] = '{2, 9'h0C3, 8, -1, 2,  0, 0, 1, 9'h03C, 1'b0, 86};

    ser   = '1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data", d8n1, 8'h00);
    check("reset_ready", rdy, 3'b000);
    check("reset_busy", busy, 3'b000);
    check("reset_frame_err", fe, 3'b000);
    check("reset_parity_err", perr, 3'b000);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      r0 = rdy_cnt[vecs[i].d];
      f0 = fe_cnt[vecs[i].d];
      send(vecs[i].d, vecs[i].dat, vecs[i].nd, vecs[i].par, vecs[i].nstop, vecs[i].stop_low, 2);
      check($sformatf("v%0d_ready_pulses", i), rdy_cnt[vecs[i].d] - r0, vecs[i].exp_rdy);
      check($sformatf("v%0d_frame_err_pulses", i), fe_cnt[vecs[i].d] - f0, vecs[i].exp_fe);
      check($sformatf("v%0d_data", i), dout(vecs[i].d), vecs[i].exp_data);
      check($sformatf("v%0d_parity_err", i), perr[vecs[i].d], vecs[i].exp_perr);
      if (vecs[i].exp_rdy != 0)
        check_range($sformatf("v%0d_latency", i), rdy_cyc[vecs[i].d] - start_cyc,
                    vecs[i].lat, vecs[i].lat + 2);
    end

    // Back-to-back frames with no idle gap.
    r0 = rdy_cnt[0];
    qs = q0.size();
    send(0, 9'h05A, 8, -1, 1, -1, 0);
    send(0, 9'h0C3, 8, -1, 1, -1, 2);
    check("b2b_ready_pulses", rdy_cnt[0] - r0, 2);
    if (q0.size() >= qs + 2) begin
      check("b2b_first", q0[qs], 8'h5A);
      check("b2b_second", q0[qs+1], 8'hC3);
    end else begin
      check("b2b_log_depth", q0.size() - qs, 2);
    end

    // Two-cycle glitch is rejected at the start-bit midpoint.
    r0 = rdy_cnt[0];
    f0 = fe_cnt[0];
    bcnt = 0;
    ser[0] = 1'b0;
    repeat (2) @(negedge clk);
    ser[0] = 1'b1;
    for (int j = 0; j < 20; j++) begin
      if (busy[0]) bcnt++;
      @(negedge clk);
    end
    check_range("glitch_busy_cycles", bcnt, 1, 5);
    check("glitch_ready", rdy_cnt[0] - r0, 0);
    check("glitch_frame_err", fe_cnt[0] - f0, 0);
    check("glitch_idle", busy[0], 1'b0);

    // Break: long low line gives one frame error and parks busy.
    f0 = fe_cnt[0];
    ser[0] = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    check("break_frame_err_pulses", fe_cnt[0] - f0, 1);
    check("break_busy", busy[0], 1'b1);
    ser[0] = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("break_release_idle", busy[0], 1'b0);
    r0 = rdy_cnt[0];
    send(0, 9'h055, 8, -1, 1, -1, 2);
    check("break_next_ready", rdy_cnt[0] - r0, 1);
    check("break_next_data", d8n1, 8'h55);

`ifdef UART_RX_MAJORITY_EN
    // One-cycle low spike at the midpoint of data bit 3 of 0xFF.
    r0 = rdy_cnt[0];
    for (int j = 0; j < 10 * CPB; j++) begin
      ser[0] = (j < CPB || j == 36) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    ser[0] = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("majority_ready", rdy_cnt[0] - r0, 1);
    check("majority_data", d8n1, 8'hFF);
`endif

    // Reset in the middle of the data bits.
    ser[0] = 1'b0;
    repeat (CPB + 20) @(negedge clk);
    check("midrst_busy_before", busy[0], 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_data", d8n1, 8'h00);
    check("midrst_data_8n2", d8n2, 8'h00);
    check("midrst_busy", busy[0], 1'b0);
    check("midrst_ready", rdy[0], 1'b0);
    check("midrst_flags", {fe[0], perr[0]}, 2'b00);
    @(negedge clk);
    ser[0] = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    r0 = rdy_cnt[0];
    send(0, 9'h081, 8, -1, 1, -1, 2);
    check("midrst_next_ready", rdy_cnt[0] - r0, 1);
    check("midrst_next_data", d8n1, 8'h81);

    check("pulse_protocol_violations", proto_err, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
